// File: rtl/risk_pkg.sv
// risk_pkg: shared types, defaults and saturating add for the risk ledger and risk check
package risk_pkg;
  localparam int RISK_ID_W = 6;
  localparam int RISK_AMT_W = 32;
  typedef enum logic [1:0] {OP_FILL, OP_REDUCE, OP_SET_MAX, OP_CLEAR} op_t;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
  typedef struct packed {
    logic [RISK_AMT_W-1:0] max;
    logic [RISK_AMT_W-1:0] acc;
    logic [RISK_AMT_W-1:0] red;
  } risk_entry_t;
  function automatic logic [RISK_AMT_W:0] sat_add(input logic [RISK_AMT_W-1:0] a, input logic [RISK_AMT_W-1:0] b);
    logic [RISK_AMT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {s[RISK_AMT_W], s[RISK_AMT_W] ? {RISK_AMT_W{1'b1}} : s[RISK_AMT_W-1:0]};
  endfunction
endpackage

// File: rtl/risk_table.sv
// risk_table: per-order register table with one write port, a lookup port and a registered write-first read port
module risk_table
  import risk_pkg::*;
#(
  parameter int ID_W = RISK_ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [ID_W-1:0] wr_id,
  input  risk_entry_t     wr_data,
  input  logic [ID_W-1:0] lk_id,
  output risk_entry_t     lk_data,
  input  logic            rd_en,
  input  logic [ID_W-1:0] rd_id,
  output logic            rd_valid,
  output risk_entry_t     rd_data
);
  risk_entry_t mem [2**ID_W];
  assign lk_data = mem[lk_id];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ID_W; i++) mem[i] <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      if (we) mem[wr_id] <= wr_data;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= (we && wr_id == rd_id) ? wr_data : mem[rd_id];
    end
  end
endmodule

// File: rtl/risk_ledger_update.sv
// risk_ledger_update: atomic read-modify-write writer for the per-order risk table
module risk_ledger_update
  import risk_pkg::*;
#(
  parameter int ID_W = RISK_ID_W,
  parameter int AMT_W = RISK_AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [1:0]       upd_op,
  input  logic [ID_W-1:0]  upd_id,
  input  logic [AMT_W-1:0] upd_amount,
  output logic             done_valid,
  output logic             done_sat,
  input  logic             rd_en,
  input  logic [ID_W-1:0]  rd_id,
  output logic             rd_valid,
  output logic [AMT_W-1:0] rd_max,
  output logic [AMT_W-1:0] rd_acc,
  output logic [AMT_W-1:0] rd_red
);
  state_t state, state_n;
  op_t op_q;
  logic [ID_W-1:0] id_q;
  logic [AMT_W-1:0] amt_q;
  risk_entry_t cur, lk_data, nxt, rd_data;
  logic [AMT_W:0] add_r;
  logic we;
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
  always_ff @(posedge clk) begin
    if (upd_valid && upd_ready) begin
      op_q <= op_t'(upd_op);
      id_q <= upd_id;
      amt_q <= upd_amount;
    end
    if (state == S_READ) cur <= lk_data;
  end
  always_comb begin
    state_n = state == S_IDLE ? (upd_valid ? S_READ : S_IDLE) : state == S_READ ? S_WRITE : S_IDLE;
    upd_ready = state == S_IDLE && !rst;
    we = state == S_WRITE && !rst;
    add_r = sat_add(op_q == OP_FILL ? cur.acc : cur.red, amt_q);
    nxt.max = op_q == OP_SET_MAX ? amt_q : cur.max;
    nxt.acc = op_q == OP_FILL ? add_r[AMT_W-1:0] : op_q == OP_CLEAR ? '0 : cur.acc;
    nxt.red = op_q == OP_REDUCE ? add_r[AMT_W-1:0] : op_q == OP_CLEAR ? '0 : cur.red;
    done_valid = we;
    done_sat = we && (op_q == OP_FILL || op_q == OP_REDUCE) && add_r[AMT_W];
  end
  risk_table #(.ID_W(ID_W)) u_table (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wr_id(id_q),
    .wr_data(nxt),
    .lk_id(id_q),
    .lk_data(lk_data),
    .rd_en(rd_en),
    .rd_id(rd_id),
    .rd_valid(rd_valid),
    .rd_data(rd_data)
  );
  assign rd_max = rd_data.max;
  assign rd_acc = rd_data.acc;
  assign rd_red = rd_data.red;
endmodule

// File: tb/tb_risk_ledger_update.sv
// tb_risk_ledger_update: directed and randomized events checked against an array-based ledger model
module tb_risk_ledger_update;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic upd_valid = 1'b0;
  logic rd_en = 1'b0;
  logic upd_ready, done_valid, done_sat, rd_valid;
  logic [1:0] upd_op = 2'd0;
  logic [5:0] upd_id = 6'd0;
  logic [5:0] rd_id = 6'd0;
  logic [31:0] upd_amount = 32'd0;
  logic [31:0] rd_max, rd_acc, rd_red;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_max [64];
  logic [31:0] m_acc [64];
  logic [31:0] m_red [64];
  always #5 clk = ~clk;
  risk_ledger_update dut (
    .clk(clk),
    .rst(rst),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_op(upd_op),
    .upd_id(upd_id),
    .upd_amount(upd_amount),
    .done_valid(done_valid),
    .done_sat(done_sat),
    .rd_en(rd_en),
    .rd_id(rd_id),
    .rd_valid(rd_valid),
    .rd_max(rd_max),
    .rd_acc(rd_acc),
    .rd_red(rd_red)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic model_clear;
    for (int i = 0; i < 64; i++) begin
      m_max[i] = 0;
      m_acc[i] = 0;
      m_red[i] = 0;
    end
  endtask
  task automatic apply(input logic [1:0] op, input int id, input logic [31:0] amt, output bit sat);
    longint unsigned s;
    sat = 0;
    if (op == 2'd0 || op == 2'd1) begin
      s = 64'(op == 2'd0 ? m_acc[id] : m_red[id]) + 64'(amt);
      sat = s > 64'hFFFF_FFFF;
      if (sat) s = 64'hFFFF_FFFF;
      if (op == 2'd0) m_acc[id] = s[31:0];
      else m_red[id] = s[31:0];
    end else if (op == 2'd2) m_max[id] = amt;
    else begin
      m_acc[id] = 0;
      m_red[id] = 0;
    end
  endtask
  task automatic check_rd(input string tag, input int id);
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_max"}, rd_max, m_max[id]);
    check({tag, "_acc"}, rd_acc, m_acc[id]);
    check({tag, "_red"}, rd_red, m_red[id]);
  endtask
  task automatic do_read(input int id);
    rd_en = 1;
    rd_id = 6'(id);
    tick;
    rd_en = 0;
    rd_id = 6'($urandom);
    check_rd("rd", id);
    tick;
    check("rd_idle_valid", rd_valid, 0);
    check("rd_hold_acc", rd_acc, m_acc[id]);
  endtask
  task automatic do_event(input logic [1:0] op, input int id, input logic [31:0] amt, input int rid);
    bit sat;
    check("ready_idle", upd_ready, 1);
    upd_valid = 1;
    upd_op = op;
    upd_id = 6'(id);
    upd_amount = amt;
    tick;
    check("ready_read", upd_ready, 0);
    check("done_read", done_valid, 0);
    upd_valid = 1'($urandom);
    upd_op = 2'($urandom);
    upd_id = 6'($urandom);
    upd_amount = $urandom;
    tick;
    apply(op, id, amt, sat);
    check("done", done_valid, 1);
    check("done_sat", done_sat, 64'(sat));
    check("ready_write", upd_ready, 0);
    rd_en = 1;
    rd_id = 6'(rid);
    tick;
    upd_valid = 0;
    rd_en = 0;
    check("done_idle", done_valid, 0);
    check_rd("commit_rd", rid);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    model_clear;
    rst = 1;
    tick;
    tick;
    check("rst_ready", upd_ready, 0);
    check("rst_done", done_valid, 0);
    check("rst_sat", done_sat, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_max", rd_max, 0);
    check("rst_rd_acc", rd_acc, 0);
    check("rst_rd_red", rd_red, 0);
    rst = 0;
    tick;
    check("post_rst_ready", upd_ready, 1);
    do_read(5);
    do_event(2'd2, 3, 32'd1000, 3);
    do_event(2'd0, 3, 32'd400, 3);
    do_event(2'd1, 3, 32'd150, 3);
    do_read(3);
    check("s2_max", rd_max, 32'd1000);
    check("s2_acc", rd_acc, 32'd400);
    check("s2_red", rd_red, 32'd150);
    do_event(2'd0, 7, 32'hFFFF_FFF0, 7);
    do_event(2'd0, 7, 32'h20, 7);
    check("sat_acc", rd_acc, 32'hFFFF_FFFF);
    do_event(2'd0, 7, 32'd1, 7);
    check("sat_hold_acc", rd_acc, 32'hFFFF_FFFF);
    do_event(2'd0, 9, 32'd50, 9);
    check("bypass_acc", rd_acc, 32'd50);
    do_event(2'd0, 9, 32'd5, 10);
    check("other_acc", rd_acc, 32'd0);
    do_event(2'd0, 3, 32'd0, 3);
    do_event(2'd3, 3, 32'hDEAD_BEEF, 3);
    check("clr_max", rd_max, 32'd1000);
    check("clr_acc", rd_acc, 32'd0);
    check("clr_red", rd_red, 32'd0);
    do_read(7);
    do_read(9);
    upd_valid = 1;
    upd_op = 2'd0;
    upd_id = 6'd2;
    upd_amount = 32'd77;
    tick;
    upd_valid = 0;
    rst = 1;
    tick;
    check("midrst_done", done_valid, 0);
    check("midrst_ready", upd_ready, 0);
    rst = 0;
    model_clear;
    tick;
    check("midrst_done_after", done_valid, 0);
    check("midrst_ready_after", upd_ready, 1);
    do_read(2);
    do_read(7);
    for (int n = 0; n < 300; n++) begin
      int id, rid;
      logic [31:0] amt;
      id = int'($urandom_range(0, 7));
      rid = $urandom_range(0, 1) == 1 ? id : int'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: amt = 32'd0;
        1: amt = 32'($urandom_range(0, 999));
        2: amt = $urandom;
        default: amt = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      endcase
      do_event(2'($urandom), id, amt, rid);
      if ($urandom_range(0, 3) == 0) do_read(int'($urandom_range(0, 63)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/risk_ledger_update.md
Name: risk_ledger_update

Overview:
- Writer side of the per-order risk table consumed by the pre-trade risk check.
- Accepts fill, reduce, limit-set and clear events over a valid/ready handshake.
- Performs a read-modify-write per order_id on the (max, accumulated, reduced) triplet held in an internal register table.
- Exposes a registered read port; the risk check uses this port to fetch the triplet before its compare.

Parameters:
- ID_W, 6, order_id width; table depth is 2**ID_W entries.
- AMT_W, 32, width of amount and of each stored field (pounds, unsigned).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- upd_valid  in  1  event present.
- upd_ready  out  1  block can accept an event this cycle.
- upd_op  in  2  event opcode: 00 FILL, 01 REDUCE, 10 SET_MAX, 11 CLEAR.
- upd_id  in  ID_W  order_id / table index.
- upd_amount  in  AMT_W  event amount; ignored for CLEAR.
- done_valid  out  1  one-cycle pulse: event committed to the table.
- done_sat  out  1  qualified by done_valid; 1 = the add saturated.
- rd_en  in  1  read request.
- rd_id  in  ID_W  read index.
- rd_valid  out  1  read data valid, one cycle after rd_en.
- rd_max  out  AMT_W  limit field.
- rd_acc  out  AMT_W  accumulated field.
- rd_red  out  AMT_W  reduced field.

Behaviour:
- Reset, when rst=1 at a clock edge:
  - All table entries are set to 0. A max of 0 makes every check fail until a limit is programmed.
  - The FSM goes to IDLE.
  - upd_ready=0 during the reset cycle, then 1 from the first cycle after rst deasserts.
  - done_valid=0, done_sat=0, rd_valid=0, rd_max=0, rd_acc=0, rd_red=0.
  - Reset mid-operation abandons the event with no partial write and no done pulse.
- FSM states: IDLE, READ, WRITE.
  - IDLE: upd_ready=1. When upd_valid&&upd_ready, latch op, id and amount, then go to READ.
  - READ: upd_ready=0. Latch table[id] into working registers, then go to WRITE.
  - WRITE: upd_ready=0. Compute and write the new entry, pulse done_valid for this cycle, then go to IDLE.
  - Accept-to-done latency is 2 cycles.
  - Throughput is one event per 3 cycles; upd_ready is deasserted for 2 cycles after each accept.
- Arithmetic, with sums formed at AMT_W+1 bits:
  - FILL: acc_new = acc + amount. If bit AMT_W is set, acc_new = all-ones and done_sat=1.
  - REDUCE: red_new = red + amount, with the same saturation rule. red is never clamped to acc; the checker handles red > acc.
  - SET_MAX: max_new = amount; acc and red unchanged; done_sat=0.
  - CLEAR: acc_new = 0 and red_new = 0; max unchanged; done_sat=0.
  - amount = 0 is legal: the entry is unchanged and done_valid still pulses.
- Read port:
  - rd_* is registered from table[rd_id] and valid the cycle after rd_en.
  - When rd_en=0, rd_valid=0 and the rd_* data holds its last value.
  - Collision, rd_en with rd_id == id in the same cycle as the WRITE-state commit: write-first bypass, so rd_* returns the new entry.
  - Reads are never stalled, including in READ and WRITE states.
- upd_op, upd_id and upd_amount are sampled only on the accept edge. Changes while upd_ready=0 have no effect.
- Back-to-back events to the same id serialise through the FSM with no hazard, because the RMW is atomic.

Decomposition:
- Package risk_pkg holds:
  - the op_t enum (FILL, REDUCE, SET_MAX, CLEAR);
  - the risk_entry_t struct {max, acc, red};
  - ID_W and AMT_W defaults.
  The risk check block uses the same package.
- Sub-module risk_table: the 2**ID_W entry register array with one write port, one registered read port and write-first bypass. The FSM and saturating adders stay in the top.

Test Plan:
- Reset, then rd id 5 -> rd_valid next cycle; max=acc=red=0; upd_ready=1 from the first post-reset cycle.
- SET_MAX id 3 amt 1000; FILL id 3 amt 400; REDUCE id 3 amt 150 -> three done pulses, each 2 cycles after its accept. A read of id 3 returns max=1000, acc=400, red=150. upd_ready is low for 2 cycles after each accept.
- FILL id 7 amt 0xFFFF_FFF0, then FILL id 7 amt 0x20 -> second done has done_sat=1 and acc=0xFFFF_FFFF. A further FILL id 7 amt 1 -> done_sat=1 and acc stays 0xFFFF_FFFF.
- FILL id 9 amt 50, with rd_en id 9 in the commit cycle -> rd_acc=50 on the next cycle (bypass). Simultaneous read of id 10 is unaffected.
- CLEAR id 3 after the scenario-2 state -> acc=0, red=0, max=1000. Entries at other ids are untouched.
- Assert rst in the READ state of a FILL id 2 amt 77 -> no done_valid, id 2 reads 0, FSM is in IDLE with upd_ready=1 the cycle after rst drops.
